// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared types and helpers for the BPSK burst generator
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GUARD    = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        SIGN_ZERO = 2'd0,
        SIGN_POS  = 2'd1,
        SIGN_NEG  = 2'd2
    } bpsk_sign_e;

    // Largest positive value representable in a signed sample of the given width;
    // a magnitude with its top bit set would flip sign once negated, so it is clamped.
    function automatic logic [31:0] clamp_amp(input logic [31:0] amp, input int unsigned width);
        logic [31:0] max_pos;
        max_pos = (32'd1 << (width - 1)) - 32'd1;
        return (amp > max_pos) ? max_pos : amp;
    endfunction

endpackage

// File: rtl/tx_symbol_map.sv
// rtl/tx_symbol_map.sv - combinational BPSK sign to signed sample mapper
module tx_symbol_map
    import tx_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       sign_sel,
    input  logic [WIDTH-1:0] amp,
    output logic [WIDTH-1:0] sample
);

    // +A, two's complement -A, or silence
    always_comb begin
        sample = '0;
        case (sign_sel)
            SIGN_POS: sample = amp;
            SIGN_NEG: sample = ~amp + WIDTH'(1);
            default:  sample = '0;
        endcase
    end

endmodule

// File: rtl/tx_burst_gen.sv
// rtl/tx_burst_gen.sv - preamble / payload / guard BPSK burst generator
module tx_burst_gen
    import tx_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     TX_AMPLITUDE,
    input  logic [LEN_WIDTH-1:0] TX_PREAMBLE_LEN,
    input  logic [LEN_WIDTH-1:0] TX_PAYLOAD_LEN,
    input  logic [LEN_WIDTH-1:0] TX_GUARD_LEN,
    input  logic                 sym_en,
    input  logic                 tx_start,
    input  logic                 bit_tdata,
    input  logic                 bit_tvalid,
    output logic                 bit_tready,
    output logic [WIDTH-1:0]     I_tdata,
    output logic                 I_tvalid,
    output logic [WIDTH-1:0]     Q_tdata,
    output logic                 Q_tvalid,
    output logic                 busy,
    output logic                 underrun
);

    tx_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0] pre_q, pre_d;
    logic [LEN_WIDTH-1:0] pay_q, pay_d;
    logic [LEN_WIDTH-1:0] grd_q, grd_d;
    logic [WIDTH-1:0]     amp_q, amp_d;
    logic                 underrun_q, underrun_d;
    logic [WIDTH-1:0]     i_q, i_d;
    logic                 tvalid_q, tvalid_d;

    logic [WIDTH-1:0]     amp_clamped;
    logic [LEN_WIDTH-1:0] cur_len;
    logic                 last_sym;
    bpsk_sign_e           sign_sel;
    logic [WIDTH-1:0]     sample;

    assign amp_clamped = WIDTH'(clamp_amp(32'(TX_AMPLITUDE), WIDTH));

    tx_symbol_map #(
        .WIDTH(WIDTH)
    ) u_map (
        .sign_sel(sign_sel),
        .amp     (amp_q),
        .sample  (sample)
    );

    // Length of the segment being played and whether this symbol closes it
    always_comb begin
        cur_len = '0;
        case (state_q)
            PREAMBLE: cur_len = pre_q;
            PAYLOAD:  cur_len = pay_q;
            GUARD:    cur_len = grd_q;
            default:  cur_len = '0;
        endcase
        last_sym = (cnt_q == cur_len - LEN_WIDTH'(1));
    end

    // Symbol sign for the current state; payload without a valid bit goes silent
    always_comb begin
        sign_sel = SIGN_ZERO;
        case (state_q)
            PREAMBLE: sign_sel = cnt_q[0] ? SIGN_NEG : SIGN_POS;
            PAYLOAD:  sign_sel = bit_tvalid ? (bit_tdata ? SIGN_POS : SIGN_NEG) : SIGN_ZERO;
            default:  sign_sel = SIGN_ZERO;
        endcase
    end

    // Next-state, config latch, counter and output register inputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        pay_d      = pay_q;
        grd_d      = grd_q;
        amp_d      = amp_q;
        underrun_d = underrun_q;
        i_d        = sym_en ? sample : i_q;
        tvalid_d   = sym_en;

        if (state_q == IDLE) begin
            if (tx_start) begin
                pre_d      = TX_PREAMBLE_LEN;
                pay_d      = TX_PAYLOAD_LEN;
                grd_d      = TX_GUARD_LEN;
                amp_d      = amp_clamped;
                underrun_d = 1'b0;
                cnt_d      = '0;
                if (TX_PREAMBLE_LEN != '0)     state_d = PREAMBLE;
                else if (TX_PAYLOAD_LEN != '0) state_d = PAYLOAD;
                else if (TX_GUARD_LEN != '0)   state_d = GUARD;
                else                           state_d = IDLE;
            end
        end else if (sym_en) begin
            if (state_q == PAYLOAD && !bit_tvalid) underrun_d = 1'b1;
            if (last_sym) begin
                cnt_d = '0;
                case (state_q)
                    PREAMBLE: state_d = (pay_q != '0) ? PAYLOAD :
                                        (grd_q != '0) ? GUARD : IDLE;
                    PAYLOAD:  state_d = (grd_q != '0) ? GUARD : IDLE;
                    default:  state_d = IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pre_q      <= '0;
            pay_q      <= '0;
            grd_q      <= '0;
            amp_q      <= '0;
            underrun_q <= 1'b0;
            i_q        <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            pay_q      <= pay_d;
            grd_q      <= grd_d;
            amp_q      <= amp_d;
            underrun_q <= underrun_d;
            i_q        <= i_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign bit_tready = sym_en && (state_q == PAYLOAD) && !rst;
    assign I_tdata    = i_q;
    assign I_tvalid   = tvalid_q;
    assign Q_tdata    = '0;
    assign Q_tvalid   = tvalid_q;
    assign busy       = (state_q != IDLE);
    assign underrun   = underrun_q;

endmodule
